// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder
// WIDTH-bit adder with carry-in and carry-out. The carry chain is cut into
// STAGES register slices of CHUNK = WIDTH/STAGES bits each. Each slice
// ripples only its own CHUNK bits per cycle. Valid/ready handshakes on the
// input and output sides allow full-rate streaming with backpressure.
//
// Optional feature: define PIPELINED_CARRY_ADDER_OVF_EN to add the registered
// signed-overflow output 'ovf', which is aligned with sum/cout.
//
// Stage k holds:
//   - valid and carry-out for the chunks completed so far
//   - completed low sum bits [(k+1)*CHUNK-1:0]
//   - operand bits not yet consumed, [WIDTH-1:(k+1)*CHUNK]
//     (these are not stored in the last stage)

module pipelined_carry_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Protect the division against STAGES < 1. That case is rejected below.
    localparam int STAGES_SAFE = (STAGES < 1) ? 1 : STAGES;
    localparam int CHUNK       = WIDTH / STAGES_SAFE;

    // Reject configurations that cannot be split into equal slices.
    if ((STAGES < 1) || ((WIDTH % STAGES_SAFE) != 0)) begin : g_bad_config
        $fatal(1, "pipelined_carry_adder: STAGES must be >= 1 and divide WIDTH");
    end

    // Per-stage valid bits, gathered into one vector so that the ready chain
    // can be formed from it.
    logic [STAGES-1:0] valid_vec;
    logic [STAGES-1:0] load_vec;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Width of the operand slice that enters this stage.
        localparam int SRCW = WIDTH - k * CHUNK;

        logic [SRCW-1:0]        s_a;
        logic [SRCW-1:0]        s_b;
        logic                   s_carry;
        logic                   s_valid;
        logic [CHUNK:0]         part;
        logic [(k+1)*CHUNK-1:0] nxt_sum;

        logic                   valid_q;
        logic                   carry_q;
        logic [(k+1)*CHUNK-1:0] sum_q;

        if (k == 0) begin : g_src_in
            assign s_a     = a;
            assign s_b     = b;
            assign s_carry = cin;
            assign s_valid = in_valid;
        end else begin : g_src_prev
            assign s_a     = g_stage[k-1].g_ops.a_q;
            assign s_b     = g_stage[k-1].g_ops.b_q;
            assign s_carry = g_stage[k-1].carry_q;
            assign s_valid = g_stage[k-1].valid_q;
        end

        // Ripple this stage's CHUNK bits.
        assign part = {1'b0, s_a[CHUNK-1:0]} + {1'b0, s_b[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, s_carry};

        if (k == 0) begin : g_sum_first
            assign nxt_sum = part[CHUNK-1:0];
        end else begin : g_sum_next
            assign nxt_sum = {part[CHUNK-1:0], g_stage[k-1].sum_q};
        end

        // A stage may load when it is empty, or when every stage downstream
        // of it is able to move. This reduces to: out_ready, or a hole at or
        // after k. The ready chain is combinational, so bubbles collapse.
        assign valid_vec[k] = valid_q;
        assign load_vec[k]  = out_ready || !(&valid_vec[STAGES-1:k]);

        // Stage register for valid, carry and completed sum bits.
        always_ff @(posedge clk) begin
            // NOTE: use non-blocking assignments for all clocked state, so that
            // every stage samples its predecessor's value from before the edge.
            if (!rst_n) begin
                // NOTE: the data registers are also cleared here. This makes
                // sum/cout read 0 after reset, not leftover values.
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (load_vec[k]) begin
                valid_q <= s_valid;
                // A bubble moves only its valid bit. Data stays put, so inputs
                // presented with in_valid=0 have no effect.
                if (s_valid) begin
                    carry_q <= part[CHUNK];
                    sum_q   <= nxt_sum;
                end
            end
        end

        if (k < STAGES - 1) begin : g_ops
            logic [SRCW-CHUNK-1:0] a_q;
            logic [SRCW-CHUNK-1:0] b_q;

            // Carry forward the operand bits that later stages have not yet used.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load_vec[k] && s_valid) begin
                    a_q <= s_a[SRCW-1:CHUNK];
                    b_q <= s_b[SRCW-1:CHUNK];
                end
            end
        end

`ifdef PIPELINED_CARRY_ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;
            logic msb_cin;

            // Carry into bit WIDTH-1, recovered from the MSB sum bit and the
            // MSB operand bits.
            assign msb_cin = s_a[CHUNK-1] ^ s_b[CHUNK-1] ^ part[CHUNK-1];

            // Signed overflow, registered so that it lines up with sum and
            // holds during stalls.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (load_vec[k] && s_valid) begin
                    ovf_q <= msb_cin ^ part[CHUNK];
                end
            end
        end
`endif
    end

    assign in_ready  = load_vec[0];
    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].carry_q;
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    assign ovf       = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule
